lss_arbiter: RTL and testbench

Shares one 5-bit pseudo-random shift-register generator between two requesters, serving each a burst of 1–16 generated words under a req/gnt handshake with round-robin fairness. The generator holds its own copy of the 5-stage recurrence. The arbiter detects the all-ones lock-up state, which the recurrence never leaves, and reseeds before serving. The block sits between the random-stimulus consumers and the generator datapath.

---
 rtl/lss_pkg.sv | 24 ++
 rtl/lss_arbiter_if.sv | 23 ++
 rtl/lss5b_step.sv | 27 ++
 rtl/lss_arbiter.sv | 76 +++++++
 tb/tb_lss_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lss_pkg.sv
// Shared constants, FSM state type and generator recurrence for the LSS arbiter.
package lss_pkg;

  localparam int unsigned LSS_W = 5;
  localparam logic [LSS_W-1:0] LSS_LOCK = 5'b11111;

  typedef enum logic [1:0] {
    IDLE,
    SEED,
    RUN
  } lss_state_e;

  // One step of the 5-stage recurrence; LSS_LOCK maps onto itself.
  function automatic logic [LSS_W-1:0] lss_next(input logic [LSS_W-1:0] q);
    logic [LSS_W-1:0] n;
    n[0] = q[4];
    n[1] = q[0];
    n[2] = q[1];
    n[3] = q[4] | q[2];
    n[4] = ~(q[4] ^ q[3]);
    return n;
  endfunction

endpackage

// File: rtl/lss_arbiter_if.sv
// Requester-side bus of the LSS arbiter: request/length in, grant and data words out.
interface lss_arbiter_if;
  import lss_pkg::*;

  logic [1:0]       req;
  logic [3:0]       len0;
  logic [3:0]       len1;
  logic [1:0]       gnt;
  logic             vld;
  logic [LSS_W-1:0] data;
  logic             last;

  modport master (
    output req, len0, len1,
    input  gnt, vld, data, last
  );

  modport slave (
    input  req, len0, len1,
    output gnt, vld, data, last
  );

endinterface

// File: rtl/lss5b_step.sv
// 5-bit generator register: load beats step beats hold, preset to the lock value.
module lss5b_step
  import lss_pkg::*;
(
  input  logic             clk,
  input  logic             rst_b,
  input  logic             en,
  input  logic             load,
  input  logic [LSS_W-1:0] seed,
  output logic [LSS_W-1:0] q
);

  logic [LSS_W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_q <= LSS_LOCK;
    end else if (load) begin
      r_q <= seed;
    end else if (en) begin
      r_q <= lss_next(r_q);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/lss_arbiter.sv
// Round-robin arbiter sharing one generator between two requesters, with lock-up reseed.
module lss_arbiter
  import lss_pkg::*;
#(
  parameter logic [LSS_W-1:0] SEED = 5'b00001
) (
  input  logic          clk,
  input  logic          rst_b,
  lss_arbiter_if.slave  bus
);

  lss_state_e       r_state;
  logic             r_owner;
  logic             r_last_served;
  logic [3:0]       r_cnt;

  logic [LSS_W-1:0] w_gen;
  logic             w_own_req;
  logic             w_win;
  logic [3:0]       w_len_win;
  logic             w_step;
  logic             w_load;

  assign w_own_req = bus.req[r_owner];
  // A lone requester wins outright; on a tie the one not served last goes first.
  assign w_win     = (bus.req == 2'b11) ? ~r_last_served : bus.req[1];
  assign w_len_win = w_win ? bus.len1 : bus.len0;
  assign w_load    = (r_state == lss_pkg::SEED);
  assign w_step    = (r_state == RUN) && w_own_req;

  lss5b_step u_gen (
    .clk   (clk),
    .rst_b (rst_b),
    .en    (w_step),
    .load  (w_load),
    .seed  (SEED),
    .q     (w_gen)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state       <= IDLE;
      r_owner       <= 1'b0;
      r_last_served <= 1'b1;
      r_cnt         <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req != 2'b00) begin
            r_owner <= w_win;
            r_cnt   <= w_len_win;
            r_state <= (w_gen == LSS_LOCK) ? lss_pkg::SEED : RUN;
          end
        end
        lss_pkg::SEED: begin
          r_state <= w_own_req ? RUN : IDLE;
        end
        RUN: begin
          if (!w_own_req || (r_cnt == 4'd0)) begin
            r_state       <= IDLE;
            r_last_served <= r_owner;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt  = (r_state == IDLE) ? 2'b00 : (r_owner ? 2'b10 : 2'b01);
  assign bus.vld  = w_step;
  assign bus.last = w_step && (r_cnt == 4'd0);
  assign bus.data = w_gen;

endmodule

// File: tb/tb_lss_arbiter.sv
// Directed and randomized checks of lss_arbiter against a burst-level reference model.
module tb_lss_arbiter;

  logic clk;
  logic rst_b;

  lss_arbiter_if bus ();

  lss_arbiter #(
    .SEED (5'b00001)
  ) u_dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Inputs staged by the stimulus, applied just after the next rising edge.
  logic [1:0] n_req;
  logic [3:0] n_len0;
  logic [3:0] n_len1;

  // Reference model: who holds the generator, words still owed, pending reseed.
  int         m_owner;
  bit         m_seed_pend;
  int         m_left;
  logic [4:0] m_gen;
  int         m_last_served;

  logic [4:0] cap_q[$];

  function automatic logic [4:0] m_next(input logic [4:0] g);
    logic [4:0] r;
    r[0] = g[4];
    r[1] = g[0];
    r[2] = g[1];
    r[3] = g[4] | g[2];
    r[4] = ~(g[4] ^ g[3]);
    return r;
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner       = -1;
    m_seed_pend   = 1'b0;
    m_left        = 0;
    m_gen         = 5'h1f;
    m_last_served = 1;
  endtask

  task automatic model_step();
    int w;
    if (!rst_b) begin
      model_reset();
      return;
    end
    if (m_owner < 0) begin
      if (bus.req != 2'b00) begin
        if (bus.req == 2'b11) w = 1 - m_last_served;
        else                  w = bus.req[0] ? 0 : 1;
        m_owner     = w;
        m_left      = ((w == 0) ? int'(bus.len0) : int'(bus.len1)) + 1;
        m_seed_pend = (m_gen == 5'h1f);
      end
    end else if (m_seed_pend) begin
      m_gen       = 5'b00001;
      m_seed_pend = 1'b0;
      if (!bus.req[m_owner]) m_owner = -1;
    end else if (bus.req[m_owner]) begin
      m_gen  = m_next(m_gen);
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_last_served = m_owner;
        m_owner       = -1;
      end
    end else begin
      m_last_served = m_owner;
      m_owner       = -1;
    end
  endtask

  // Single compare point: every cycle's outputs against the model.
  task automatic check();
    int e_gnt;
    int e_vld;
    int e_last;
    e_gnt = 0;
    e_vld = 0;
    if (m_owner >= 0) begin
      e_gnt = (m_owner == 0) ? 1 : 2;
      if (!m_seed_pend && bus.req[m_owner]) e_vld = 1;
    end
    e_last = (e_vld == 1 && m_left == 1) ? 1 : 0;
    cmp("gnt",  int'(bus.gnt),  e_gnt);
    cmp("vld",  int'(bus.vld),  e_vld);
    cmp("data", int'(bus.data), int'(m_gen));
    cmp("last", int'(bus.last), e_last);
    if (bus.vld) cap_q.push_back(bus.data);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    bus.req  = n_req;
    bus.len0 = n_len0;
    bus.len1 = n_len1;
    @(negedge clk);
    check();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         nl;
    int         nv;
    int         v_at_last;
    int         first_gnt;
    bit         done;
    logic [1:0] g [6];
    logic [4:0] gexp;

    rst_b    = 1'b0;
    n_req    = 2'b00;
    n_len0   = 4'd0;
    n_len1   = 4'd0;
    bus.req  = 2'b00;
    bus.len0 = 4'd0;
    bus.len1 = 4'd0;
    model_reset();

    repeat (2) @(negedge clk);
    cmp("rst_gnt",  int'(bus.gnt),  0);
    cmp("rst_vld",  int'(bus.vld),  0);
    cmp("rst_last", int'(bus.last), 0);
    cmp("rst_data", int'(bus.data), 'b11111);
    check();
    rst_b = 1'b1;

    // First burst after reset: one SEED cycle then three words.
    n_req  = 2'b01;
    n_len0 = 4'd2;
    cycle();
    cap_q.delete();
    cycle();
    cmp("t1_seed_gnt", int'(bus.gnt), 'b01);
    cmp("t1_seed_vld", int'(bus.vld), 0);
    repeat (3) cycle();
    cmp("t1_last", int'(bus.last), 1);
    n_req = 2'b00;
    cycle();
    cmp("t1_idle_gnt", int'(bus.gnt), 0);
    cmp("t1_idle_gen", int'(bus.data), 'b01010);
    cmp("t1_words", cap_q.size(), 3);
    if (cap_q.size() == 3) begin
      cmp("t1_w0", int'(cap_q[0]), 'b00001);
      cmp("t1_w1", int'(cap_q[1]), 'b10010);
      cmp("t1_w2", int'(cap_q[2]), 'b01101);
    end

    // Both requesters held with single-word bursts: grants alternate from requester 1.
    n_req  = 2'b11;
    n_len0 = 4'd0;
    n_len1 = 4'd0;
    cycle();
    cap_q.delete();
    nl = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) n_req = 2'b00;
      cycle();
      g[i] = bus.gnt;
      if (bus.vld && bus.last) nl++;
      if (i == 4) n_req = 2'b00;
    end
    cmp("t2_g0", int'(g[0]), 'b10);
    cmp("t2_g1", int'(g[1]), 'b00);
    cmp("t2_g2", int'(g[2]), 'b01);
    cmp("t2_g3", int'(g[3]), 'b00);
    cmp("t2_g4", int'(g[4]), 'b10);
    cmp("t2_lasts", nl, 3);
    cmp("t2_words", cap_q.size(), 3);
    if (cap_q.size() == 3) begin
      cmp("t2_w0", int'(cap_q[0]), 'b01010);
      cmp("t2_w1", int'(cap_q[1]), 'b00100);
      cmp("t2_w2", int'(cap_q[2]), 'b11000);
    end

    // Requester 1 aborts a 16-word burst after three words.
    n_req  = 2'b10;
    n_len1 = 4'd15;
    cycle();
    cap_q.delete();
    repeat (3) cycle();
    n_req = 2'b00;
    cycle();
    cmp("t3_drop_vld", int'(bus.vld), 0);
    cmp("t3_drop_gnt", int'(bus.gnt), 'b10);
    cmp("t3_drop_data", int'(bus.data), 'b11111);
    cycle();
    cmp("t3_idle_gnt", int'(bus.gnt), 0);
    cmp("t3_words", cap_q.size(), 3);
    if (cap_q.size() == 3) begin
      cmp("t3_w0", int'(cap_q[0]), 'b11001);
      cmp("t3_w1", int'(cap_q[1]), 'b11011);
      cmp("t3_w2", int'(cap_q[2]), 'b11111);
    end

    // Generator reached lock-up naturally; next burst reseeds, then reset hits mid-run.
    n_req  = 2'b01;
    n_len0 = 4'd3;
    cycle();
    cycle();
    cmp("t4_seed_gnt", int'(bus.gnt), 'b01);
    cmp("t4_seed_vld", int'(bus.vld), 0);
    cycle();
    cmp("t4_w0", int'(bus.data), 'b00001);
    cycle();
    cmp("t4_w1", int'(bus.data), 'b10010);
    rst_b = 1'b0;
    model_reset();
    #1;
    cmp("t4_rst_gnt",  int'(bus.gnt),  0);
    cmp("t4_rst_vld",  int'(bus.vld),  0);
    cmp("t4_rst_data", int'(bus.data), 'b11111);
    check();
    n_req = 2'b00;
    cycle();
    rst_b = 1'b1;

    // Maximum burst with req held: SEED, then exactly 16 words.
    n_req  = 2'b01;
    n_len0 = 4'd15;
    cycle();
    cap_q.delete();
    nv        = 0;
    nl        = 0;
    v_at_last = 0;
    first_gnt = 1;
    done      = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      cycle();
      if (bus.gnt != 2'b00 && first_gnt == 1) begin
        first_gnt = 0;
        cmp("t5_seed_vld", int'(bus.vld), 0);
      end
      if (bus.vld) nv++;
      if (bus.vld && bus.last) begin
        nl++;
        v_at_last = nv;
        done      = 1'b1;
        n_req     = 2'b00;
      end
    end
    cmp("t5_done", int'(done), 1);
    cmp("t5_words", nv, 16);
    cmp("t5_lasts", nl, 1);
    cmp("t5_last_pos", v_at_last, 16);
    if (cap_q.size() > 0) cmp("t5_w0", int'(cap_q[0]), 'b00001);
    cycle();
    gexp = 5'b00001;
    for (int i = 0; i < 16; i++) gexp = m_next(gexp);
    cmp("t5_gen16", int'(bus.data), int'(gexp));

    // Randomized traffic with aborts, ties and occasional asynchronous reset.
    for (int i = 0; i < 4000; i++) begin
      for (int j = 0; j < 2; j++) begin
        if (!n_req[j]) n_req[j] = ($urandom_range(3) == 0);
        else if ($urandom_range(19) == 0) n_req[j] = 1'b0;
      end
      n_len0 = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(2));
      n_len1 = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(2));
      cycle();
      if ($urandom_range(299) == 0) begin
        rst_b = 1'b0;
        model_reset();
        #2;
        check();
        cycle();
        rst_b = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
